morse_round_ctrl: RTL and testbench

- Parametrised game-round controller for the morse tumbler game. Sequences IDLE -> P1 entry -> P2 entry -> RESULT.
- Classifies key presses as dot or dash by hold time and stores player 1's message in an internal symbol buffer.
- Compares player 2's symbols against that buffer one by one, tracks errors and timeout, and keeps a running win score.
- Sits between the debounced board keys and the translator/VGA path, which uses the buffer read port and the per-symbol result pulses.

---
 rtl/morse_round_if.sv | 37 +++
 rtl/morse_round_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_morse_round_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/morse_round_if.sv
// Morse round controller bus: key/done/tick inputs, display read port,
// and round status outputs (state, counters, per-symbol judgement, score).
interface morse_round_if #(
  parameter int LEN_W   = 5,
  parameter int ERR_W   = 4,
  parameter int SCORE_W = 4
);
  logic               tick;
  logic               key_n;
  logic               done_n;
  logic [LEN_W-1:0]   rd_addr;
  logic [1:0]         rd_sym;
  logic [1:0]         state;
  logic [LEN_W-1:0]   p1_len;
  logic [LEN_W-1:0]   p2_idx;
  logic               sym_valid;
  logic               sym_ok;
  logic [1:0]         last_sym;
  logic [ERR_W-1:0]   errors;
  logic               win;
  logic               overflow;
  logic [SCORE_W-1:0] score;

  modport master (
    output tick, key_n, done_n, rd_addr,
    input  rd_sym, state, p1_len, p2_idx,
    input  sym_valid, sym_ok, last_sym,
    input  errors, win, overflow, score
  );

  modport slave (
    input  tick, key_n, done_n, rd_addr,
    output rd_sym, state, p1_len, p2_idx,
    output sym_valid, sym_ok, last_sym,
    output errors, win, overflow, score
  );
endinterface

// File: rtl/morse_round_ctrl.sv
// Morse game round FSM: IDLE -> P1 entry -> P2 entry -> RESULT.
// Ports: clock, resetn (async low), bus (slave) with keys, read port, status.
module morse_round_ctrl #(
  parameter int DEPTH         = 16,
  parameter int LEN_W         = 5,
  parameter int DASH_TICKS    = 2,
  parameter int TIMEOUT_TICKS = 8,
  parameter int ERR_W         = 4,
  parameter int SCORE_W       = 4
) (
  input logic           clock,
  input logic           resetn,
  morse_round_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(DASH_TICKS + 1);
  localparam int TW = (TIMEOUT_TICKS > 0) ?
                      $clog2(TIMEOUT_TICKS + 1) : 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
  localparam logic [HW-1:0]    HOLD_L  = HW'(DASH_TICKS);
  localparam logic [TW-1:0]    TO_L    = TW'(TIMEOUT_TICKS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2,
    RES  = 2'd3
  } st_e;

  st_e                state_q, state_d;
  logic               key_q, done_q;
  logic [HW-1:0]      hold_q, hold_d;
  logic [TW-1:0]      to_q, to_d;
  logic [LEN_W-1:0]   p1_len_q, p1_len_d;
  logic [LEN_W-1:0]   p2_idx_q, p2_idx_d;
  logic               sym_valid_q, sym_valid_d;
  logic               sym_ok_q, sym_ok_d;
  logic [1:0]         last_sym_q, last_sym_d;
  logic [ERR_W-1:0]   errors_q, errors_d;
  logic               win_q, win_d;
  logic               overflow_q, overflow_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [1:0]         mem_q [DEPTH];
  logic               buf_we;
  logic               judge_ok;
  logic [1:0]         sym;

  logic key_press, key_rel, done_press;
  assign key_press  = key_q & ~bus.key_n;
  assign key_rel    = ~key_q & bus.key_n;
  assign done_press = done_q & ~bus.done_n;
  assign sym        = (hold_q >= HOLD_L) ? 2'b11 : 2'b01;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    to_d        = to_q;
    p1_len_d    = p1_len_q;
    p2_idx_d    = p2_idx_q;
    sym_valid_d = 1'b0;
    sym_ok_d    = sym_ok_q;
    last_sym_d  = last_sym_q;
    errors_d    = errors_q;
    win_d       = win_q;
    overflow_d  = overflow_q;
    score_d     = score_q;
    buf_we      = 1'b0;
    judge_ok    = 1'b0;

    if (key_press)
      hold_d = '0;
    else if (bus.tick && !bus.key_n && hold_q != HOLD_L)
      hold_d = hold_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (done_press) state_d = P1;
      end
      P1: begin
        if (key_rel) begin
          last_sym_d = sym;
          if (p1_len_q < DEPTH_L) begin
            buf_we   = 1'b1;
            p1_len_d = p1_len_q + 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
        // post-release length decides, so a final release counts
        if (done_press && p1_len_d != '0) begin
          state_d = P2;
          to_d    = '0;
        end
      end
      P2: begin
        if (key_press || key_rel)
          to_d = '0;
        else if (bus.tick && bus.key_n && to_q != TO_L)
          to_d = to_q + 1'b1;
        if (key_rel) begin
          last_sym_d  = sym;
          sym_valid_d = 1'b1;
          if (p2_idx_q < p1_len_q) begin
            judge_ok = (sym == mem_q[p2_idx_q[AW-1:0]]);
            p2_idx_d = p2_idx_q + 1'b1;
          end
          sym_ok_d = judge_ok;
          if (!judge_ok && errors_q != '1)
            errors_d = errors_q + 1'b1;
        end
        if (done_press) begin
          state_d = RES;
          win_d   = (errors_d == '0) && (p2_idx_d == p1_len_q);
        end else if (TIMEOUT_TICKS != 0 && to_d == TO_L) begin
          state_d = RES;
          win_d   = 1'b0;
        end
        if (state_d == RES && win_d && score_q != '1)
          score_d = score_q + 1'b1;
      end
      RES: begin
        if (done_press) begin
          state_d    = IDLE;
          p1_len_d   = '0;
          p2_idx_d   = '0;
          errors_d   = '0;
          overflow_d = 1'b0;
          win_d      = 1'b0;
          sym_ok_d   = 1'b0;
          last_sym_d = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      key_q       <= 1'b1;
      done_q      <= 1'b1;
      hold_q      <= '0;
      to_q        <= '0;
      p1_len_q    <= '0;
      p2_idx_q    <= '0;
      sym_valid_q <= 1'b0;
      sym_ok_q    <= 1'b0;
      last_sym_q  <= 2'b00;
      errors_q    <= '0;
      win_q       <= 1'b0;
      overflow_q  <= 1'b0;
      score_q     <= '0;
    end else begin
      state_q     <= state_d;
      key_q       <= bus.key_n;
      done_q      <= bus.done_n;
      hold_q      <= hold_d;
      to_q        <= to_d;
      p1_len_q    <= p1_len_d;
      p2_idx_q    <= p2_idx_d;
      sym_valid_q <= sym_valid_d;
      sym_ok_q    <= sym_ok_d;
      last_sym_q  <= last_sym_d;
      errors_q    <= errors_d;
      win_q       <= win_d;
      overflow_q  <= overflow_d;
      score_q     <= score_d;
    end
  end

  // contents are masked by p1_len, so no reset needed
  always_ff @(posedge clock) begin
    if (buf_we) mem_q[p1_len_q[AW-1:0]] <= sym;
  end

  assign bus.rd_sym = (bus.rd_addr < p1_len_q) ?
                      mem_q[bus.rd_addr[AW-1:0]] : 2'b00;
  assign bus.state     = state_q;
  assign bus.p1_len    = p1_len_q;
  assign bus.p2_idx    = p2_idx_q;
  assign bus.sym_valid = sym_valid_q;
  assign bus.sym_ok    = sym_ok_q;
  assign bus.last_sym  = last_sym_q;
  assign bus.errors    = errors_q;
  assign bus.win       = win_q;
  assign bus.overflow  = overflow_q;
  assign bus.score     = score_q;
endmodule

// File: tb/tb_morse_round_ctrl.sv
// Bench for morse_round_ctrl: directed and random rounds against
// a message-level reference model.
module tb_morse_round_ctrl;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  morse_round_if #(.LEN_W(5), .ERR_W(4), .SCORE_W(4)) bus ();

  morse_round_ctrl #(
    .DEPTH(16), .LEN_W(5), .DASH_TICKS(2),
    .TIMEOUT_TICKS(8), .ERR_W(4), .SCORE_W(4)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int m_score = 0;
  int m_p1[$];
  int m_p2[$];
  bit vq[$];
  bit rnd_hold = 0;

  always @(negedge clock)
    if (bus.sym_valid === 1'b1) vq.push_back(bus.sym_ok);

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_tick();
    bus.tick = 1'b1;
    @(negedge clock);
    bus.tick = 1'b0;
  endtask

  function automatic int hold_for(input int s);
    if (!rnd_hold) return (s == 3) ? 3 : 0;
    return (s == 3) ? int'($urandom_range(2, 4))
                    : int'($urandom_range(0, 1));
  endfunction

  task automatic key_sym(input int s);
    int t;
    t = hold_for(s);
    bus.key_n = 1'b0;
    cyc(1);
    repeat (t) pulse_tick();
    bus.key_n = 1'b1;
    cyc(2);
  endtask

  task automatic done_btn();
    bus.done_n = 1'b0;
    cyc(1);
    bus.done_n = 1'b1;
    cyc(2);
  endtask

  task automatic check_rd(input string nm);
    int len;
    len = (m_p1.size() > 16) ? 16 : m_p1.size();
    for (int a = 0; a < 32; a++) begin
      int exp_s;
      bus.rd_addr = 5'(a);
      #1;
      exp_s = (a < len) ? m_p1[a] : 0;
      n_checks++;
      if (bus.rd_sym !== 2'(exp_s)) begin
        n_errors++;
        $display("FAIL %s rd_sym[%0d] got %0d exp %0d",
                 nm, a, bus.rd_sym, exp_s);
      end
    end
  endtask

  // full round from IDLE using m_p1 / m_p2; model at message level
  task automatic play_round(input string nm);
    int len, nerr, nidx, ok;
    bit exp_win;
    len = (m_p1.size() > 16) ? 16 : m_p1.size();
    done_btn();
    n_checks++;
    if (bus.state !== 2'd1) begin
      n_errors++;
      $display("FAIL %s p1 state got %0d exp 1", nm, bus.state);
    end
    foreach (m_p1[i]) begin
      key_sym(m_p1[i]);
      n_checks++;
      if (bus.last_sym !== 2'(m_p1[i])) begin
        n_errors++;
        $display("FAIL %s last_sym got %0d exp %0d",
                 nm, bus.last_sym, m_p1[i]);
      end
    end
    n_checks++;
    if (bus.p1_len !== 5'(len) ||
        bus.overflow !== (m_p1.size() > 16)) begin
      n_errors++;
      $display("FAIL %s p1_len/ovf got %0d/%0d exp %0d/%0d", nm,
               bus.p1_len, bus.overflow, len, m_p1.size() > 16);
    end
    check_rd(nm);
    done_btn();
    n_checks++;
    if (bus.state !== 2'd2) begin
      n_errors++;
      $display("FAIL %s p2 state got %0d exp 2", nm, bus.state);
    end
    vq.delete();
    foreach (m_p2[i]) key_sym(m_p2[i]);
    done_btn();
    nerr = 0;
    nidx = (m_p2.size() < len) ? m_p2.size() : len;
    n_checks++;
    if (vq.size() != m_p2.size()) begin
      n_errors++;
      $display("FAIL %s pulses got %0d exp %0d",
               nm, vq.size(), m_p2.size());
    end
    foreach (m_p2[i]) begin
      ok = (i < len) && (m_p2[i] == m_p1[i]);
      if (!ok) nerr++;
      if (i < vq.size()) begin
        n_checks++;
        if (vq[i] !== ok[0]) begin
          n_errors++;
          $display("FAIL %s sym_ok[%0d] got %0d exp %0d",
                   nm, i, vq[i], ok);
        end
      end
    end
    if (nerr > 15) nerr = 15;
    exp_win = (nerr == 0) && (m_p2.size() == len);
    if (exp_win && m_score < 15) m_score++;
    n_checks++;
    if (bus.errors !== 4'(nerr) || bus.p2_idx !== 5'(nidx)) begin
      n_errors++;
      $display("FAIL %s err/idx got %0d/%0d exp %0d/%0d",
               nm, bus.errors, bus.p2_idx, nerr, nidx);
    end
    n_checks++;
    if (bus.state !== 2'd3 || bus.win !== exp_win ||
        bus.score !== 4'(m_score)) begin
      n_errors++;
      $display("FAIL %s st/win/score got %0d/%0d/%0d exp 3/%0d/%0d",
               nm, bus.state, bus.win, bus.score, exp_win, m_score);
    end
    done_btn();
    n_checks++;
    if (bus.state !== 2'd0 || bus.p1_len !== 5'd0 ||
        bus.overflow !== 1'b0 || bus.errors !== 4'd0 ||
        bus.win !== 1'b0 || bus.last_sym !== 2'd0 ||
        bus.score !== 4'(m_score)) begin
      n_errors++;
      $display("FAIL %s idle clear st %0d len %0d ovf %0d sc %0d",
               nm, bus.state, bus.p1_len, bus.overflow, bus.score);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus.state !== 2'd0 || bus.score !== 4'd0 ||
        bus.p1_len !== 5'd0 || bus.p2_idx !== 5'd0 ||
        bus.errors !== 4'd0 || bus.overflow !== 1'b0 ||
        bus.win !== 1'b0 || bus.sym_valid !== 1'b0 ||
        bus.last_sym !== 2'd0) begin
      n_errors++;
      $display("FAIL reset st %0d sc %0d len %0d err %0d",
               bus.state, bus.score, bus.p1_len, bus.errors);
    end
    m_p1.delete();
    check_rd("reset");
  endtask

  task automatic test_match();
    m_p1 = '{1, 3, 1};
    m_p2 = '{1, 3, 1};
    play_round("match");
  endtask

  task automatic test_mismatch();
    m_p1 = '{1, 3, 1};
    m_p2 = '{1, 1, 1, 1};
    play_round("mismatch");
  endtask

  task automatic test_overflow();
    m_p1.delete();
    repeat (17) m_p1.push_back(1);
    m_p2.delete();
    play_round("overflow");
  endtask

  task automatic test_timeout();
    done_btn();
    key_sym(1);
    done_btn();
    repeat (7) pulse_tick();
    cyc(2);
    n_checks++;
    if (bus.state !== 2'd2) begin
      n_errors++;
      $display("FAIL timeout_early state got %0d exp 2", bus.state);
    end
    pulse_tick();
    cyc(2);
    n_checks++;
    if (bus.state !== 2'd3 || bus.win !== 1'b0 ||
        bus.score !== 4'(m_score)) begin
      n_errors++;
      $display("FAIL timeout st/win/score got %0d/%0d/%0d exp 3/0/%0d",
               bus.state, bus.win, bus.score, m_score);
    end
    done_btn();
  endtask

  task automatic test_release_with_done();
    done_btn();
    key_sym(1);
    key_sym(3);
    done_btn();
    vq.delete();
    key_sym(1);
    bus.key_n = 1'b0;
    cyc(1);
    repeat (3) pulse_tick();
    bus.key_n = 1'b1;
    bus.done_n = 1'b0;
    cyc(1);
    bus.done_n = 1'b1;
    cyc(2);
    if (m_score < 15) m_score++;
    n_checks++;
    if (vq.size() != 2 || bus.p2_idx !== 5'd2 ||
        bus.errors !== 4'd0) begin
      n_errors++;
      $display("FAIL rel_done pulses %0d idx %0d err %0d exp 2/2/0",
               vq.size(), bus.p2_idx, bus.errors);
    end
    n_checks++;
    if (bus.state !== 2'd3 || bus.win !== 1'b1 ||
        bus.score !== 4'(m_score)) begin
      n_errors++;
      $display("FAIL rel_done st/win/score got %0d/%0d/%0d exp 3/1/%0d",
               bus.state, bus.win, bus.score, m_score);
    end
    done_btn();
  endtask

  task automatic test_random();
    int len, mode;
    rnd_hold = 1;
    for (int r = 0; r < 24; r++) begin
      m_p1.delete();
      m_p2.delete();
      len = $urandom_range(1, 6);
      repeat (len) m_p1.push_back(($urandom_range(0, 1) != 0) ? 3 : 1);
      mode = $urandom_range(0, 9);
      if (mode < 6) begin
        m_p2 = m_p1;
      end else begin
        repeat ($urandom_range(0, len + 3))
          m_p2.push_back(($urandom_range(0, 1) != 0) ? 3 : 1);
      end
      play_round($sformatf("rand%0d", r));
    end
    rnd_hold = 0;
  endtask

  task automatic test_reset_mid();
    done_btn();
    key_sym(1);
    done_btn();
    key_sym(1);
    resetn = 1'b0;
    m_score = 0;
    m_p1.delete();
    cyc(1);
    n_checks++;
    if (bus.state !== 2'd0 || bus.score !== 4'd0 ||
        bus.p1_len !== 5'd0) begin
      n_errors++;
      $display("FAIL reset_mid st %0d sc %0d len %0d exp 0/0/0",
               bus.state, bus.score, bus.p1_len);
    end
    check_rd("reset_mid");
    vq.delete();
    resetn = 1'b1;
    cyc(5);
    n_checks++;
    if (vq.size() != 0 || bus.state !== 2'd0) begin
      n_errors++;
      $display("FAIL post_reset pulses %0d st %0d exp 0/0",
               vq.size(), bus.state);
    end
  endtask

  initial begin
    bus.tick = 1'b0;
    bus.key_n = 1'b1;
    bus.done_n = 1'b1;
    bus.rd_addr = '0;
    cyc(3);
    resetn = 1'b1;
    cyc(2);
    test_reset();
    test_match();
    test_mismatch();
    test_overflow();
    test_timeout();
    test_release_with_done();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
